// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: answers READ, FAST_READ and RDID from a byte-read memory port.
// All SPI pins are oversampled in sys_clk; nothing in this block is clocked by spi_clk.
module spi_flash_responder #(
  parameter int          ADDR_W      = 24,
  parameter int          SYNC_STAGES = 2,
  parameter logic [23:0] JEDEC_ID    = 24'h20BA18
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              err_cmd,
  output logic              underrun
);

  typedef enum logic [2:0] {
    WAIT_CS,
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    ID,
    IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_fall;

  state_t                 state;
  logic [4:0]             bit_cnt;
  logic [6:0]             cmd_sh;
  logic [7:0]             cmd_next;
  logic                   fast;
  logic [ADDR_W-1:0]      addr;
  logic [ADDR_W-1:0]      addr_next;
  logic [7:0]             buf_data;
  logic                   buf_full;
  logic [6:0]             sh;
  logic [1:0]             id_idx;
  logic                   stale;
  logic                   req_pend;
  logic                   rd_ok;
  logic [7:0]             load_byte;
  logic [7:0]             id_byte;
  logic [7:0]             out_byte;

  function automatic logic [7:0] jedec_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    jedec_byte = JEDEC_ID[23:16];
      2'd1:    jedec_byte = JEDEC_ID[15:8];
      default: jedec_byte = JEDEC_ID[7:0];
    endcase
  endfunction

  // Control synchronisers reset low so a reset taken with cs_n low stays in WAIT_CS.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  always_ff @(posedge sys_clk) begin
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;

  assign cmd_next  = {cmd_sh, mosi_s};
  assign addr_next = {addr[ADDR_W-2:0], mosi_s};
  // A response to a request that was overtaken by a byte boundary is stale and dropped.
  assign rd_ok     = mem_req & mem_rvalid & ~stale;
  assign load_byte = rd_ok ? mem_rdata : (buf_full ? buf_data : 8'hFF);
  assign id_byte   = jedec_byte(id_idx);
  assign out_byte  = (state == ID) ? id_byte : load_byte;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= WAIT_CS;
      bit_cnt     <= 5'd0;
      fast        <= 1'b0;
      buf_full    <= 1'b0;
      id_idx      <= 2'd0;
      stale       <= 1'b0;
      req_pend    <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      err_cmd     <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      err_cmd  <= 1'b0;
      underrun <= 1'b0;

      if (mem_req && mem_rvalid) begin
        mem_req <= 1'b0;
        stale   <= 1'b0;
        if (!stale) begin
          buf_data <= mem_rdata;
          buf_full <= 1'b1;
        end
      end else if (!mem_req && req_pend) begin
        mem_req  <= 1'b1;
        mem_addr <= addr;
        req_pend <= 1'b0;
      end

      if (state != WAIT_CS && state != IDLE && cs_s) begin
        // Deselect aborts everything, including a response landing this cycle.
        state       <= IDLE;
        busy        <= 1'b0;
        bit_cnt     <= 5'd0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
        mem_req     <= 1'b0;
        req_pend    <= 1'b0;
        stale       <= 1'b0;
        buf_full    <= 1'b0;
      end else begin
        case (state)
          WAIT_CS: begin
            busy <= ~cs_s;
            if (cs_s) state <= IDLE;
          end

          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              busy    <= 1'b1;
              bit_cnt <= 5'd0;
            end
          end

          CMD: begin
            if (sclk_rise) begin
              cmd_sh  <= cmd_next[6:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
                case (cmd_next)
                  8'h03: begin
                    state <= ADDR;
                    fast  <= 1'b0;
                  end
                  8'h0B: begin
                    state <= ADDR;
                    fast  <= 1'b1;
                  end
                  8'h9F: begin
                    state  <= ID;
                    id_idx <= 2'd0;
                  end
                  default: begin
                    state   <= IGNORE;
                    err_cmd <= 1'b1;
                  end
                endcase
              end
            end
          end

          ADDR: begin
            if (sclk_rise) begin
              addr    <= addr_next;
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd23) begin
                bit_cnt  <= 5'd0;
                mem_addr <= addr_next;
                mem_req  <= 1'b1;
                buf_full <= 1'b0;
                state    <= fast ? DUMMY : DATA;
              end
            end
          end

          DUMMY: begin
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
                state   <= DATA;
              end
            end
          end

          DATA, ID: begin
            if (sclk_fall) begin
              if (bit_cnt == 5'd0) begin
                sh          <= out_byte[6:0];
                spi_miso    <= out_byte[7];
                spi_miso_oe <= 1'b1;
                bit_cnt     <= 5'd1;
                if (state == ID) begin
                  id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                end else begin
                  underrun <= ~rd_ok & ~buf_full;
                  buf_full <= 1'b0;
                  addr     <= addr + ADDR_W'(1);
                  req_pend <= 1'b1;
                  // Any request still open now is for the byte just consumed.
                  if ((mem_req && !mem_rvalid) || (!mem_req && req_pend)) stale <= 1'b1;
                end
              end else begin
                sh       <= {sh[5:0], 1'b0};
                spi_miso <= sh[6];
                bit_cnt  <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
              end
            end
          end

          IGNORE: begin
            busy <= 1'b1;
          end

          default: begin
            state <= WAIT_CS;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI master tasks, a latency-programmable memory
// model answering addr[7:0]^8'hA5, and immediate assertions at each comparison point.
module tb_spi_flash_responder;

  localparam int H = 8;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        sclk       = 1'b0;
  logic        cs_n       = 1'b1;
  logic        mosi       = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  mem_rdata  = 8'h00;
  logic        miso;
  logic        oe;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        busy;
  logic        err_cmd;
  logic        underrun;

  int n_chk = 0;
  int n_pass = 0;

  int          lat      = 0;
  int          cnt      = 0;
  logic        inflight = 1'b0;
  logic [23:0] req_addr = 24'h0;
  logic [23:0] req_hist [0:255];
  int          req_n    = 0;
  int          ur_cnt   = 0;
  int          err_cnt  = 0;
  int          oe_cnt   = 0;
  int          late_cnt = 0;

  spi_flash_responder #(
    .ADDR_W      (24),
    .SYNC_STAGES (2),
    .JEDEC_ID    (24'h20BA18)
  ) dut (
    .sys_clk     (clk),
    .sys_rst     (rst),
    .spi_clk     (sclk),
    .spi_cs_n    (cs_n),
    .spi_mosi    (mosi),
    .spi_miso    (miso),
    .spi_miso_oe (oe),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .err_cmd     (err_cmd),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  // Memory model and pulse monitors, all on the inactive edge.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (underrun) ur_cnt++;
    if (err_cmd) err_cnt++;
    if (oe) oe_cnt++;
    if (!inflight && mem_req) begin
      inflight = 1'b1;
      cnt      = lat;
      req_addr = mem_addr;
      req_hist[req_n[7:0]] = mem_addr;
      req_n++;
    end
    if (inflight) begin
      if (cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = req_addr[7:0] ^ 8'hA5;
        inflight   = 1'b0;
        if (!mem_req) late_cnt++;
      end else begin
        cnt--;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion, required completion before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    tick(H);
    sclk = 1'b1;
    tick(H);
    r    = miso;
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic cs_lo();
    cs_n = 1'b0;
    tick(H);
  endtask

  task automatic cs_hi();
    cs_n = 1'b1;
    tick(H);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] d;
    spi_byte(op, d);
    spi_byte(a[23:16], d);
    spi_byte(a[15:8], d);
    spi_byte(a[7:0], d);
  endtask

  initial begin
    logic [7:0]  rx;
    logic        rb;
    int          rq;
    int          ub;
    int          eb;
    int          ob;
    int          lb;
    logic [7:0]  exp_b [4];
    logic [23:0] exp_a [4];

    // Reset state
    tick(4);
    check("rst_miso", miso, 0);
    check("rst_oe", oe, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_err_cmd", err_cmd, 0);
    check("rst_underrun", underrun, 0);
    rst = 1'b0;
    tick(8);
    check("idle_busy", busy, 0);

    // 1: READ at 0x10, zero-latency memory
    lat = 0; rq = req_n; ub = ur_cnt;
    exp_b = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
    cs_lo();
    send_hdr(8'h03, 24'h000010);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      check("t1_data", rx, exp_b[i]);
    end
    cs_hi(); tick(40);
    check("t1_underrun", ur_cnt - ub, 0);
    check("t1_nreq", req_n - rq, 5);
    for (int i = 0; i < 5; i++) check("t1_addr", req_hist[rq + i], 24'h10 + i);

    // 2: FAST_READ across the address wrap, 20-cycle latency
    lat = 20; rq = req_n; ub = ur_cnt;
    exp_b = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
    exp_a = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
    cs_lo();
    send_hdr(8'h0B, 24'hFFFFFE);
    spi_byte(8'h00, rx);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      check("t2_data", rx, exp_b[i]);
    end
    cs_hi(); tick(40);
    check("t2_underrun", ur_cnt - ub, 0);
    for (int i = 0; i < 4; i++) check("t2_addr", req_hist[rq + i], exp_a[i]);

    // 3: READ with latency beyond the first-byte budget
    lat = 10; ub = ur_cnt;
    cs_lo();
    send_hdr(8'h03, 24'h000080);
    spi_byte(8'h00, rx);
    check("t3_first_ff", rx, 8'hFF);
    spi_byte(8'h00, rx);
    check("t3_second", rx, 8'h24);
    cs_hi(); tick(40);
    check("t3_underrun", ur_cnt - ub, 1);

    // 4: RDID, four bytes wrap through the 3-byte ID
    lat = 0; rq = req_n;
    exp_b = '{8'h20, 8'hBA, 8'h18, 8'h20};
    cs_lo();
    spi_byte(8'h9F, rx);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      check("t4_id", rx, exp_b[i]);
    end
    cs_hi(); tick(20);
    check("t4_no_req", req_n - rq, 0);

    // 5: unsupported opcode, then a normal READ
    rq = req_n; eb = err_cnt; ob = oe_cnt;
    cs_lo();
    spi_byte(8'h5A, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    check("t5_busy_ignore", busy, 1);
    cs_hi(); tick(20);
    check("t5_err_pulse", err_cnt - eb, 1);
    check("t5_oe_quiet", oe_cnt - ob, 0);
    check("t5_no_req", req_n - rq, 0);
    check("t5_idle", busy, 0);
    cs_lo();
    send_hdr(8'h03, 24'h000020);
    spi_byte(8'h00, rx);
    check("t5_read", rx, 8'h85);
    cs_hi(); tick(20);
    check("t5_err_once", err_cnt - eb, 1);

    // 6a: deselect mid-DATA with a request open; its response arrives late
    lat = 30; lb = late_cnt;
    cs_lo();
    send_hdr(8'h03, 24'h000040);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, rb);
    check("t6_req_open", mem_req, 1);
    cs_n = 1'b1;
    tick(4);
    check("t6_oe_off", oe, 0);
    check("t6_miso_low", miso, 0);
    check("t6_req_dropped", mem_req, 0);
    check("t6_idle", busy, 0);
    tick(40);
    check("t6_late_rvalid_seen", late_cnt - lb, 1);
    check("t6_req_still_low", mem_req, 0);
    check("t6_still_idle", busy, 0);

    // 6b: reset mid-ADDR with cs_n held low
    lat = 0; rq = req_n; ob = oe_cnt; ub = ur_cnt;
    cs_lo();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, rb);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) spi_bit(1'b1, rb);
    spi_byte(8'h55, rx);
    spi_byte(8'h00, rx);
    check("t6_waitcs_busy", busy, 1);
    check("t6_waitcs_req", req_n - rq, 0);
    check("t6_waitcs_oe", oe_cnt - ob, 0);
    cs_hi(); tick(6);
    check("t6_after_cs_idle", busy, 0);
    cs_lo();
    send_hdr(8'h03, 24'h000033);
    spi_byte(8'h00, rx);
    check("t6_read_after", rx, 8'h96);
    cs_hi(); tick(20);
    check("t6_underrun", ur_cnt - ub, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
